// File: rtl/i2f_arbiter.sv
// Four-requester round-robin front end to one shared int32 -> IEEE-754 single
// converter (truncating), with a valid/ready result port and a saturating precision-lost count.
module i2f_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req,
   input  logic [127:0]     d,
   output logic [3:0]       gnt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_float,
   output logic             out_plost,
   output logic [1:0]       out_id,
   output logic [CNT_W-1:0] lost_cnt
);

   typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2} state_t;

   state_t      state_r;
   logic [1:0]  last_r;
   logic [1:0]  id_cap_r;
   logic [31:0] op_r;
   logic [1:0]  winner_s;
   logic [1:0]  cand_s;
   logic [31:0] sel_op_s;
   logic [32:0] conv_s;

   // Returns {p_lost, float}; the fraction is truncated, never rounded.
   function automatic logic [32:0] int_to_float(input logic [31:0] v);
      logic        sign;
      logic [31:0] mag;
      logic [31:0] norm;
      logic [4:0]  sa;
      logic [7:0]  expo;
      sign = v[31];
      mag  = sign ? (~v + 32'd1) : v;
      sa   = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (mag[i]) begin
            sa = 5'(31 - i);
         end
      end
      norm = mag << sa;
      expo = 8'd158 - {3'd0, sa};
      if (mag == 32'd0) begin
         return 33'd0;
      end else begin
         return {|norm[7:0], sign, expo, norm[30:8]};
      end
   endfunction

   // Round-robin pick: scan downward so the nearest requester after last_r wins.
   always_comb begin
      winner_s = last_r;
      cand_s   = last_r;
      for (int k = 3; k >= 0; k--) begin
         cand_s = last_r + 2'(k + 1);
         if (req[cand_s]) begin
            winner_s = cand_s;
         end else begin
            winner_s = winner_s;
         end
      end
   end

   // Grant is issued in the capture cycle itself so result latency stays at two clocks.
   always_comb begin
      if (!rst && (|req) && ((state_r == IDLE) || ((state_r == DONE) && out_ready))) begin
         gnt = 4'b0001 << winner_s;
      end else begin
         gnt = 4'b0000;
      end
   end

   assign sel_op_s = d[{winner_s, 5'd0} +: 32];
   assign conv_s   = int_to_float(op_r);

   // Control FSM, operand capture, result registers and lost counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         last_r    <= 2'd3;
         id_cap_r  <= 2'd0;
         op_r      <= 32'd0;
         out_valid <= 1'b0;
         out_float <= 32'd0;
         out_plost <= 1'b0;
         out_id    <= 2'd0;
         lost_cnt  <= '0;
      end else begin
         if (|gnt) begin
            op_r     <= sel_op_s;
            id_cap_r <= winner_s;
            last_r   <= winner_s;
         end
         case (state_r)
            IDLE: begin
               if (|req) begin
                  state_r <= CONV;
               end else begin
                  state_r <= IDLE;
               end
            end
            CONV: begin
               out_float <= conv_s[31:0];
               out_plost <= conv_s[32];
               out_id    <= id_cap_r;
               out_valid <= 1'b1;
               state_r   <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (out_plost && (lost_cnt != {CNT_W{1'b1}})) begin
                     lost_cnt <= lost_cnt + CNT_W'(1);
                  end
                  if (|req) begin
                     state_r <= CONV;
                  end else begin
                     state_r <= IDLE;
                  end
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2f_arbiter.sv
// Self-checking bench for i2f_arbiter: conversion vector table, fairness,
// backpressure, mid-conversion reset and counter saturation, with a result scoreboard.
module tb_i2f_arbiter;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       req;
   logic [127:0]     d;
   logic [3:0]       gnt;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_float;
   logic             out_plost;
   logic [1:0]       out_id;
   logic [CNT_W-1:0] lost_cnt;

   i2f_arbiter #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .req(req), .d(d), .gnt(gnt),
      .out_valid(out_valid), .out_ready(out_ready), .out_float(out_float),
      .out_plost(out_plost), .out_id(out_id), .lost_cnt(lost_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] f;
      logic        p;
   } exp_t;

   typedef struct {
      logic [31:0] d;
      logic [31:0] f;
      logic        p;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   exp_t        sb[$];
   exp_t        e_push;
   exp_t        e_pop;
   int          gidx;
   logic [31:0] exp_f[4];
   logic        exp_p[4];
   int          exp_lost = 0;
   vec_t        vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Scoreboard: push on grant, pop and compare on handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (gnt != 4'b0000) begin
            chk("gnt_onehot", 64'($onehot(gnt)), 64'd1);
            gidx = 0;
            for (int i = 0; i < 4; i++) if (gnt[i]) gidx = i;
            e_push.id = 2'(gidx);
            e_push.f  = exp_f[gidx];
            e_push.p  = exp_p[gidx];
            sb.push_back(e_push);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_valid", 64'd1, 64'd0);
            end else begin
               e_pop = sb.pop_front();
               chk("out_id", 64'(out_id), 64'(e_pop.id));
               chk("out_float", 64'(out_float), 64'(e_pop.f));
               chk("out_plost", 64'(out_plost), 64'(e_pop.p));
               if (e_pop.p && exp_lost < (2 ** CNT_W) - 1) exp_lost++;
            end
         end
      end
   end

   task automatic wait_gnt(output logic ok);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (gnt != 4'b0000) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic run_one(input int r, input logic [31:0] val, input logic [31:0] f, input logic p);
      logic ok;
      int   n;
      @(posedge clk); #1;
      d[r*32 +: 32] = val;
      exp_f[r] = f;
      exp_p[r] = p;
      out_ready = 1'b1;
      req = 4'b0001 << r;
      wait_gnt(ok);
      chk("grant_timeout", 64'(ok), 64'd1);
      chk("gnt_single", 64'(gnt), 64'(4'b0001 << r));
      @(posedge clk); #1;
      req = 4'b0000;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 10);
      chk("latency", 64'(n), 64'd2);
      @(posedge clk); #1;
      @(negedge clk);
      chk("lost_cnt", 64'(lost_cnt), 64'(exp_lost));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1);
   end

   initial begin
      logic ok;
      vecs[0] = '{32'h00000001, 32'h3F800000, 1'b0};
      vecs[1] = '{32'hFFFFFFFF, 32'hBF800000, 1'b0};
      vecs[2] = '{32'h00000000, 32'h00000000, 1'b0};
      vecs[3] = '{32'h80000000, 32'hCF000000, 1'b0};
      vecs[4] = '{32'h7FFFFFFF, 32'h4EFFFFFF, 1'b1};
      vecs[5] = '{32'h00FFFFFF, 32'h4B7FFFFF, 1'b0};
      vecs[6] = '{32'h01000001, 32'h4B800000, 1'b1};
      vecs[7] = '{32'h00000064, 32'h42C80000, 1'b0};
      vecs[8] = '{32'hFFFFFF9C, 32'hC2C80000, 1'b0};
      vecs[9] = '{32'h00000002, 32'h40000000, 1'b0};

      rst = 1'b1; req = 4'b0000; d = 128'd0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin exp_f[i] = 32'd0; exp_p[i] = 1'b0; end
      repeat (3) @(negedge clk);
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_float", 64'(out_float), 64'd0);
      chk("rst_plost", 64'(out_plost), 64'd0);
      chk("rst_id", 64'(out_id), 64'd0);
      chk("rst_lost", 64'(lost_cnt), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Fairness with all four requesting continuously.
      for (int i = 0; i < 4; i++) begin
         d[i*32 +: 32] = vecs[i].d;
         exp_f[i] = vecs[i].f;
         exp_p[i] = vecs[i].p;
      end
      req = 4'b1111;
      for (int g = 0; g < 8; g++) begin
         wait_gnt(ok);
         chk("fair_timeout", 64'(ok), 64'd1);
         chk("fair_order", 64'(gnt), 64'(4'b0001 << (g % 4)));
      end
      @(posedge clk); #1;
      req = 4'b0000;
      repeat (4) @(negedge clk);
      chk("fair_drain", 64'(sb.size()), 64'd0);

      for (int i = 0; i < 10; i++) run_one(i % 4, vecs[i].d, vecs[i].f, vecs[i].p);

      // Backpressure: result held, no grant, then handshake and grant together.
      @(posedge clk); #1;
      d[31:0] = 32'h00000064; exp_f[0] = 32'h42C80000; exp_p[0] = 1'b0;
      out_ready = 1'b0; req = 4'b0001;
      wait_gnt(ok);
      chk("bp_timeout", 64'(ok), 64'd1);
      @(posedge clk); #1;
      req = 4'b0010; d[63:32] = 32'hFFFFFF9C; exp_f[1] = 32'hC2C80000; exp_p[1] = 1'b0;
      @(negedge clk);
      chk("bp_conv_gnt", 64'(gnt), 64'd0);
      chk("bp_conv_valid", 64'(out_valid), 64'd0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_valid", 64'(out_valid), 64'd1);
         chk("bp_gnt", 64'(gnt), 64'd0);
         chk("bp_float", 64'(out_float), 64'h42C80000);
         chk("bp_id", 64'(out_id), 64'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_same_cycle_gnt", 64'(gnt), 64'd2);
      chk("bp_same_cycle_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
      req = 4'b0000;
      repeat (4) @(negedge clk);
      chk("bp_drain", 64'(sb.size()), 64'd0);

      // Reset during CONV discards the in-flight result.
      @(posedge clk); #1;
      d[31:0] = 32'hFFFFFFFF; exp_f[0] = 32'hBF800000; exp_p[0] = 1'b0; req = 4'b0001;
      wait_gnt(ok);
      chk("mid_timeout", 64'(ok), 64'd1);
      @(posedge clk); #1;
      req = 4'b0000; rst = 1'b1;
      sb.delete();
      exp_lost = 0;
      @(negedge clk);
      chk("mid_gnt", 64'(gnt), 64'd0);
      chk("mid_valid", 64'(out_valid), 64'd0);
      chk("mid_float", 64'(out_float), 64'd0);
      chk("mid_plost", 64'(out_plost), 64'd0);
      chk("mid_id", 64'(out_id), 64'd0);
      chk("mid_lost", 64'(lost_cnt), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("mid_no_stale", 64'(out_valid), 64'd0);
      end
      @(posedge clk); #1;
      for (int i = 1; i < 4; i++) begin exp_f[i] = vecs[i].f; exp_p[i] = vecs[i].p; d[i*32 +: 32] = vecs[i].d; end
      req = 4'b1111;
      @(negedge clk);
      chk("post_rst_priority", 64'(gnt), 64'd1);
      @(posedge clk); #1;
      req = 4'b0000;
      repeat (4) @(negedge clk);
      chk("post_rst_drain", 64'(sb.size()), 64'd0);

      // Saturation of the lost counter.
      for (int s = 0; s < 9; s++) run_one(s % 4, 32'h7FFFFFFF, 32'h4EFFFFFF, 1'b1);
      chk("lost_saturated", 64'(lost_cnt), 64'd7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
